two_server_arbiter: RTL and testbench
=====================================

TWO_SERVER_ARBITER -- requirements
Module: two_server_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 8, number of requesters; only value 8 supported (3-bit ids).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  8  request vector; bit k = requester k wants a server.
REQ-005 SHALL have port done0  input  1  single-cycle release pulse from server 0.
REQ-006 SHALL have port done1  input  1  single-cycle release pulse from server 1.
REQ-007 SHALL have port gnt0_valid  output  1  server 0 holds a grant.
REQ-008 SHALL have port gnt0_id  output  3  requester holding server 0.
REQ-009 SHALL have port gnt1_valid  output  1  server 1 holds a grant.
REQ-010 SHALL have port gnt1_id  output  3  requester holding server 1.
REQ-011 SHALL have port NONE  output  1  registered; 1 when req==0 was sampled with at least one server IDLE.
REQ-012 SHALL have port grant_cnt  output  8  total grants issued, wraps 255->0.

Function
REQ-013 SHALL keep one FSM per server, states IDLE and BUSY; gntX_valid = (state==BUSY); all outputs registered.
REQ-014 SHALL keep a 3-bit round-robin pointer ptr; priority order ptr, ptr-1, ..., ptr+1 (descending, mod 8).
REQ-015 SHALL form eligible = req with bits of any requester currently held by a BUSY server cleared.
REQ-016 SHALL pick first = highest-priority eligible bit, second = next eligible bit after first in priority order.
REQ-017 SHALL, both servers IDLE: server 0 takes first, server 1 takes second; only one eligible -> server 0 only.
REQ-018 SHALL, exactly one server IDLE: that server takes first.
REQ-019 SHALL make a granted server BUSY with gntX_id set on the next rising edge (one-cycle latency from req).
REQ-020 SHALL hold gntX_valid and gntX_id constant while BUSY regardless of req changes.
REQ-021 SHALL return server X to IDLE on the edge after doneX=1 while BUSY; no new grant to X on that same edge.
REQ-022 SHALL ignore doneX while server X is IDLE.
REQ-023 SHALL allow done0 and done1 in the same cycle; both servers return to IDLE together.
REQ-024 SHALL update ptr on any grant edge to (last granted id - 1) mod 8, last = second if two grants else first.
REQ-025 SHALL leave ptr unchanged on edges with no grant.
REQ-026 SHALL increment grant_cnt by number of grants issued that edge (0, 1 or 2), mod 256.
REQ-027 SHALL never grant the same requester to both servers simultaneously.

Reset
REQ-028 SHALL, while reset=1, asynchronously force: both FSMs IDLE, gnt0_valid=gnt1_valid=0, gnt0_id=gnt1_id=0, NONE=0, grant_cnt=0, ptr=7.
REQ-029 SHALL abandon any held grant on reset mid-operation; first grant possible on first edge after reset deasserts.

Verification
REQ-030 SHALL check: reset, req=8'b1000_0001 -> next edge gnt0=(1,7), gnt1=(1,0), grant_cnt=2, ptr=7.
REQ-031 SHALL check: reset, req=8'b0000_0100 -> gnt0=(1,2), gnt1_valid=0, ptr=1, grant_cnt=1.
REQ-032 SHALL check: req=8'hFF, both BUSY (7,6); pulse done0 -> gnt0_valid=0 one cycle, then gnt0=(1,5) next edge, gnt1 stays (1,6).
REQ-033 SHALL check: req=8'hFF with done0/done1 pulsed together each time both BUSY -> grant pairs (7,6),(5,4),(3,2),(1,0),(7,6).
REQ-034 SHALL check: reset asserted mid-cycle while both BUSY -> gnt valids, ids, grant_cnt go 0 immediately, without a clock edge.
REQ-035 SHALL check: req=0 after reset -> NONE=1 next edge, no grants, grant_cnt=0; done pulses while IDLE have no effect.

Source files
------------

// File: rtl/two_server_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | two_server_arbiter: round-robin assignment of N_REQ requesters onto     |
// | two servers, each with an IDLE/BUSY state machine.  Revision: 1.0       |
// +------------------------------------------------------------------------+
module two_server_arbiter #(
  parameter int N_REQ = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done0,
  input  logic             done1,
  output logic             gnt0_valid,
  output logic [2:0]       gnt0_id,
  output logic             gnt1_valid,
  output logic [2:0]       gnt1_id,
  output logic             NONE,
  output logic [7:0]       grant_cnt
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state0_q, state0_d, state1_q, state1_d;
  logic [ID_W-1:0]   id0_q, id0_d, id1_q, id1_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              none_q, none_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [N_REQ-1:0]  held, elig;
  logic [ID_W-1:0]   idx, first, second, gid0, gid1;
  logic              found1, found2, grant0, grant1, idle0, idle1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state0_q <= IDLE;
      state1_q <= IDLE;
      id0_q    <= '0;
      id1_q    <= '0;
      ptr_q    <= ID_W'(N_REQ - 1);
      none_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state0_q <= state0_d;
      state1_q <= state1_d;
      id0_q    <= id0_d;
      id1_q    <= id1_d;
      ptr_q    <= ptr_d;
      none_q   <= none_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    held   = '0;
    idx    = '0;
    first  = '0;
    second = '0;
    found1 = 1'b0;
    found2 = 1'b0;
    grant0 = 1'b0;
    grant1 = 1'b0;
    gid0   = '0;
    gid1   = '0;
    idle0  = (state0_q == IDLE);
    idle1  = (state1_q == IDLE);

    // A requester already served must not be offered to the other server.
    if (!idle0) held[id0_q] = 1'b1;
    if (!idle1) held[id1_q] = 1'b1;
    elig = req & ~held;

    // Walk priority ptr, ptr-1, ... and keep the first two eligible hits.
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr_q - ID_W'(k);
      if (elig[idx]) begin
        if (!found1) begin
          first  = idx;
          found1 = 1'b1;
        end else if (!found2) begin
          second = idx;
          found2 = 1'b1;
        end
      end
    end

    if (idle0 && idle1) begin
      grant0 = found1;
      gid0   = first;
      grant1 = found2;
      gid1   = second;
    end else if (idle0) begin
      grant0 = found1;
      gid0   = first;
    end else if (idle1) begin
      grant1 = found1;
      gid1   = first;
    end

    state0_d = state0_q;
    state1_d = state1_q;
    id0_d    = id0_q;
    id1_d    = id1_q;

    // A server being released this edge stays IDLE for at least one cycle.
    if (!idle0) begin
      if (done0) state0_d = IDLE;
    end else if (grant0) begin
      state0_d = BUSY;
      id0_d    = gid0;
    end

    if (!idle1) begin
      if (done1) state1_d = IDLE;
    end else if (grant1) begin
      state1_d = BUSY;
      id1_d    = gid1;
    end

    ptr_d = ptr_q;
    if (grant1)      ptr_d = gid1 - ID_W'(1);
    else if (grant0) ptr_d = gid0 - ID_W'(1);

    cnt_d  = cnt_q + 8'(grant0) + 8'(grant1);
    none_d = (req == '0) && (idle0 || idle1);
  end

  assign gnt0_valid = (state0_q == BUSY);
  assign gnt1_valid = (state1_q == BUSY);
  assign gnt0_id    = 3'(id0_q);
  assign gnt1_id    = 3'(id1_q);
  assign NONE       = none_q;
  assign grant_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_two_server_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_two_server_arbiter: vector table, directed corner cases and random   |
// | traffic against a rule-level reference model. Revision: 1.0             |
// +------------------------------------------------------------------------+
module tb_two_server_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = '0;
  logic       done0 = 1'b0, done1 = 1'b0;
  logic       gnt0_valid, gnt1_valid, NONE;
  logic [2:0] gnt0_id, gnt1_id;
  logic [7:0] grant_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  two_server_arbiter #(.N_REQ(8)) dut (
    .clk(clk), .reset(reset), .req(req), .done0(done0), .done1(done1),
    .gnt0_valid(gnt0_valid), .gnt0_id(gnt0_id),
    .gnt1_valid(gnt1_valid), .gnt1_id(gnt1_id),
    .NONE(NONE), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: server occupancy, holder ids, pointer, counters.
  bit m_busy[2];
  int m_id[2];
  int m_ptr;
  bit m_none;
  int m_cnt;

  task automatic mdl_reset();
    m_busy[0] = 0; m_busy[1] = 0;
    m_id[0] = 0;   m_id[1] = 0;
    m_ptr = 7; m_none = 0; m_cnt = 0;
  endtask

  task automatic mdl_step(input logic [7:0] r, input bit d0, input bit d1);
    int order[$];
    int g[2];
    int last;
    bit nb[2];
    g[0] = -1; g[1] = -1; last = -1;
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (m_ptr - k + 8) % 8;
      if (r[c] && !(m_busy[0] && m_id[0] == c) && !(m_busy[1] && m_id[1] == c))
        order.push_back(c);
    end
    if (!m_busy[0] && !m_busy[1]) begin
      if (order.size() > 0) g[0] = order[0];
      if (order.size() > 1) g[1] = order[1];
    end else if (!m_busy[0]) begin
      if (order.size() > 0) g[0] = order[0];
    end else if (!m_busy[1]) begin
      if (order.size() > 0) g[1] = order[0];
    end
    m_none = (r == 0) && (!m_busy[0] || !m_busy[1]);
    nb[0] = m_busy[0] ? !d0 : (g[0] >= 0);
    nb[1] = m_busy[1] ? !d1 : (g[1] >= 0);
    for (int s = 0; s < 2; s++) begin
      if (g[s] >= 0) begin
        m_id[s] = g[s];
        m_cnt = (m_cnt + 1) % 256;
        last = g[s];
      end
      m_busy[s] = nb[s];
    end
    if (last >= 0) m_ptr = (last + 7) % 8;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read 1ns after the rising edge.
  task automatic step(input logic [7:0] r, input bit d0, input bit d1);
    @(negedge clk);
    req = r; done0 = d0; done1 = d1;
    @(posedge clk);
    mdl_step(r, d0, d1);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; done0 = 1'b0; done1 = 1'b0;
    mdl_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " v0"}, int'(gnt0_valid), int'(m_busy[0]));
    chk({tag, " v1"}, int'(gnt1_valid), int'(m_busy[1]));
    chk({tag, " none"}, int'(NONE), int'(m_none));
    chk({tag, " cnt"}, int'(grant_cnt), m_cnt);
    if (m_busy[0]) chk({tag, " id0"}, int'(gnt0_id), m_id[0]);
    if (m_busy[1]) chk({tag, " id1"}, int'(gnt1_id), m_id[1]);
    if (gnt0_valid && gnt1_valid) chk({tag, " distinct"}, int'(gnt0_id != gnt1_id), 1);
  endtask

  typedef struct {
    logic [7:0] r;
    bit d0, d1;
    bit v0; int id0;
    bit v1; int id1;
    bit none; int cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{8'h81, 0, 0, 1, 7, 1, 0, 0, 2};
    tbl[1] = '{8'h00, 1, 1, 0, 0, 0, 0, 0, 2};
    tbl[2] = '{8'h00, 0, 0, 0, 0, 0, 0, 1, 2};
    tbl[3] = '{8'h04, 0, 0, 1, 2, 0, 0, 0, 3};
    tbl[4] = '{8'hFF, 0, 0, 1, 2, 1, 1, 0, 4};
    tbl[5] = '{8'hFF, 1, 0, 0, 0, 1, 1, 0, 4};
    tbl[6] = '{8'hFF, 0, 0, 1, 0, 1, 1, 0, 5};
    tbl[7] = '{8'h00, 0, 1, 1, 0, 0, 0, 0, 5};
    tbl[8] = '{8'h00, 0, 0, 1, 0, 0, 0, 1, 5};

    mdl_reset();
    #2;
    chk("rst v0", int'(gnt0_valid), 0);
    chk("rst v1", int'(gnt1_valid), 0);
    chk("rst id0", int'(gnt0_id), 0);
    chk("rst id1", int'(gnt1_id), 0);
    chk("rst none", int'(NONE), 0);
    chk("rst cnt", int'(grant_cnt), 0);
    do_reset();

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, tbl[i].d0, tbl[i].d1);
      chk($sformatf("tbl%0d v0", i), int'(gnt0_valid), int'(tbl[i].v0));
      chk($sformatf("tbl%0d v1", i), int'(gnt1_valid), int'(tbl[i].v1));
      chk($sformatf("tbl%0d none", i), int'(NONE), int'(tbl[i].none));
      chk($sformatf("tbl%0d cnt", i), int'(grant_cnt), tbl[i].cnt);
      if (tbl[i].v0) chk($sformatf("tbl%0d id0", i), int'(gnt0_id), tbl[i].id0);
      if (tbl[i].v1) chk($sformatf("tbl%0d id1", i), int'(gnt1_id), tbl[i].id1);
    end

    // Single requester after reset: server 0 only, pointer moves to 1.
    do_reset();
    step(8'h04, 0, 0);
    chk("one v0", int'(gnt0_valid), 1);
    chk("one id0", int'(gnt0_id), 2);
    chk("one v1", int'(gnt1_valid), 0);
    chk("one cnt", int'(grant_cnt), 1);
    step(8'h04, 1, 0);
    step(8'hFF, 0, 0);
    chk("one ptr id0", int'(gnt0_id), 1);
    chk("one ptr id1", int'(gnt1_id), 0);

    // Release of server 0 alone.
    do_reset();
    step(8'hFF, 0, 0);
    chk("rel id0", int'(gnt0_id), 7);
    chk("rel id1", int'(gnt1_id), 6);
    step(8'hFF, 1, 0);
    chk("rel gap v0", int'(gnt0_valid), 0);
    chk("rel gap id1", int'(gnt1_id), 6);
    step(8'hFF, 0, 0);
    chk("rel v0", int'(gnt0_valid), 1);
    chk("rel id0b", int'(gnt0_id), 5);
    chk("rel v1", int'(gnt1_valid), 1);
    chk("rel id1b", int'(gnt1_id), 6);

    // Joint releases rotate through pairs (5,4),(3,2),(1,0),(7,6).
    do_reset();
    step(8'hFF, 0, 0);
    for (int p = 0; p < 4; p++) begin
      int e;
      e = (5 - 2 * p + 8) % 8;
      step(8'hFF, 1, 1);
      chk($sformatf("pair%0d idle", p), int'(gnt0_valid | gnt1_valid), 0);
      step(8'hFF, 0, 0);
      chk($sformatf("pair%0d id0", p), int'(gnt0_id), e);
      chk($sformatf("pair%0d id1", p), int'(gnt1_id), e - 1);
    end

    // Asynchronous reset in the middle of a cycle.
    step(8'hFF, 0, 0);
    #2;
    reset = 1'b1;
    mdl_reset();
    #1;
    chk("arst v0", int'(gnt0_valid), 0);
    chk("arst v1", int'(gnt1_valid), 0);
    chk("arst id0", int'(gnt0_id), 0);
    chk("arst id1", int'(gnt1_id), 0);
    chk("arst cnt", int'(grant_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    step(8'hFF, 0, 0);
    chk("arst after id0", int'(gnt0_id), 7);
    chk("arst after id1", int'(gnt1_id), 6);

    // No requests, done pulses while idle.
    do_reset();
    step(8'h00, 1, 1);
    chk("idle none", int'(NONE), 1);
    chk("idle v", int'(gnt0_valid | gnt1_valid), 0);
    chk("idle cnt", int'(grant_cnt), 0);
    step(8'h00, 1, 0);
    step(8'h81, 0, 0);
    chk("idle after id0", int'(gnt0_id), 7);
    chk("idle after id1", int'(gnt1_id), 0);
    chk("idle after cnt", int'(grant_cnt), 2);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      step(r, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
